// File: rtl/collision_ctrl.sv
// collision_ctrl: counts frog/car pixel overlap per video frame and runs the
// lives sequence (hit -> freeze -> respawn -> grace -> play, or game over).
module collision_ctrl #(
   parameter int c_NUM_CARS      = 4,
   parameter int c_LIVES         = 3,
   parameter int c_HIT_PIXELS    = 4,
   parameter int c_FREEZE_FRAMES = 60,
   parameter int c_GRACE_FRAMES  = 30
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst_n,
   input  logic                  i_Game_Active,
   input  logic                  i_Frame_Start,
   input  logic                  i_Draw_frog,
   input  logic [c_NUM_CARS-1:0] i_Draw_car,
   output logic                  o_Hit,
   output logic [c_NUM_CARS-1:0] o_Hit_Car,
   output logic                  o_Freeze,
   output logic                  o_Respawn,
   output logic                  o_Grace,
   output logic [2:0]            o_Lives,
   output logic                  o_Game_Over
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PLAY   = 3'd1,
      FREEZE = 3'd2,
      GRACE  = 3'd3,
      OVER   = 3'd4
   } state_t;

   localparam logic [2:0] LIVES_INIT  = 3'(c_LIVES);
   localparam logic [7:0] HIT_MIN     = 8'(c_HIT_PIXELS);
   localparam logic [7:0] FREEZE_LAST = 8'(c_FREEZE_FRAMES - 1);
   localparam logic [7:0] GRACE_LAST  = 8'(c_GRACE_FRAMES - 1);

   state_t                  state_q, state_d;
   logic [2:0]              lives_q, lives_d;
   logic [7:0]              ovl_cnt_q, ovl_cnt_d;
   logic [c_NUM_CARS-1:0]   mask_q, mask_d;
   logic [7:0]              frame_cnt_q, frame_cnt_d;
   logic                    hit_q, hit_d;
   logic [c_NUM_CARS-1:0]   hit_car_q, hit_car_d;
   logic                    respawn_q, respawn_d;

   logic overlap;
   assign overlap = i_Draw_frog & (|i_Draw_car);

   // Next-state logic; every register holds unless a rule below changes it.
   always_comb begin
      state_d     = state_q;
      lives_d     = lives_q;
      ovl_cnt_d   = ovl_cnt_q;
      mask_d      = mask_q;
      frame_cnt_d = frame_cnt_q;
      hit_d       = 1'b0;
      hit_car_d   = hit_car_q;
      respawn_d   = 1'b0;

      if (!i_Game_Active) begin
         // Leaving the game beats any frame evaluation; lives are kept.
         state_d   = IDLE;
         hit_car_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               lives_d     = LIVES_INIT;
               ovl_cnt_d   = '0;
               mask_d      = '0;
               frame_cnt_d = '0;
               state_d     = PLAY;
            end
            PLAY: begin
               if (i_Frame_Start) begin
                  if (ovl_cnt_q >= HIT_MIN) begin
                     hit_d       = 1'b1;
                     hit_car_d   = mask_q;
                     frame_cnt_d = '0;
                     if (lives_q <= 3'd1) begin
                        lives_d = 3'd0;
                        state_d = OVER;
                     end else begin
                        lives_d = lives_q - 3'd1;
                        state_d = FREEZE;
                     end
                  end
                  // The frame-start pixel belongs to the new frame.
                  ovl_cnt_d = overlap ? 8'd1 : 8'd0;
                  mask_d    = overlap ? i_Draw_car : '0;
               end else if (overlap) begin
                  if (ovl_cnt_q != 8'hFF) begin
                     ovl_cnt_d = ovl_cnt_q + 8'd1;
                  end
                  mask_d = mask_q | i_Draw_car;
               end
            end
            FREEZE: begin
               if (i_Frame_Start) begin
                  if (frame_cnt_q == FREEZE_LAST) begin
                     respawn_d   = 1'b1;
                     frame_cnt_d = '0;
                     state_d     = GRACE;
                  end else begin
                     frame_cnt_d = frame_cnt_q + 8'd1;
                  end
               end
            end
            GRACE: begin
               if (i_Frame_Start) begin
                  if (frame_cnt_q == GRACE_LAST) begin
                     frame_cnt_d = '0;
                     ovl_cnt_d   = '0;
                     mask_d      = '0;
                     state_d     = PLAY;
                  end else begin
                     frame_cnt_d = frame_cnt_q + 8'd1;
                  end
               end
            end
            OVER: begin
               state_d = OVER;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state_q     <= IDLE;
         lives_q     <= LIVES_INIT;
         ovl_cnt_q   <= '0;
         mask_q      <= '0;
         frame_cnt_q <= '0;
         hit_q       <= 1'b0;
         hit_car_q   <= '0;
         respawn_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         lives_q     <= lives_d;
         ovl_cnt_q   <= ovl_cnt_d;
         mask_q      <= mask_d;
         frame_cnt_q <= frame_cnt_d;
         hit_q       <= hit_d;
         hit_car_q   <= hit_car_d;
         respawn_q   <= respawn_d;
      end
   end

   assign o_Hit       = hit_q;
   assign o_Hit_Car   = hit_car_q;
   assign o_Respawn   = respawn_q;
   assign o_Lives     = lives_q;
   assign o_Freeze    = (state_q == FREEZE);
   assign o_Grace     = (state_q == GRACE);
   assign o_Game_Over = (state_q == OVER);

endmodule

// File: tb/tb_collision_ctrl.sv
// Bench for collision_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a frame-level behavioural model.
module tb_collision_ctrl;

   localparam int NC    = 4;
   localparam int LIVES = 3;
   localparam int HIT   = 4;
   localparam int FRZ   = 2;
   localparam int GRC   = 2;

   localparam int PH_IDLE = 0, PH_PLAY = 1, PH_FREEZE = 2, PH_GRACE = 3, PH_OVER = 4;

   logic          clk = 1'b0;
   logic          rst_n_in, act_in, fs_in, frog_in;
   logic [NC-1:0] car_in;
   logic          hit_out, freeze_out, respawn_out, grace_out, over_out;
   logic [NC-1:0] hit_car_out;
   logic [2:0]    lives_out;

   always #5 clk = ~clk;

   collision_ctrl #(
      .c_NUM_CARS(NC), .c_LIVES(LIVES), .c_HIT_PIXELS(HIT),
      .c_FREEZE_FRAMES(FRZ), .c_GRACE_FRAMES(GRC)
   ) dut (
      .i_Clk(clk), .i_Rst_n(rst_n_in), .i_Game_Active(act_in),
      .i_Frame_Start(fs_in), .i_Draw_frog(frog_in), .i_Draw_car(car_in),
      .o_Hit(hit_out), .o_Hit_Car(hit_car_out), .o_Freeze(freeze_out),
      .o_Respawn(respawn_out), .o_Grace(grace_out), .o_Lives(lives_out),
      .o_Game_Over(over_out)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cycle    = 0;

   // Reference model: phase, lives, pixels this frame, cars seen, frames left.
   int          m_phase = PH_IDLE;
   int          m_lives = LIVES;
   int          m_pix   = 0;
   logic [NC-1:0] m_cars = '0;
   int          m_left  = 0;
   logic        m_hit   = 1'b0;
   logic        m_resp  = 1'b0;
   logic [NC-1:0] m_hitcar = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, got, exp);
      end
   endtask

   task automatic model_update(input logic rst_n, input logic act, input logic fs,
                               input logic frog, input logic [NC-1:0] car);
      logic ov;
      ov     = frog && (car != 0);
      m_hit  = 1'b0;
      m_resp = 1'b0;
      if (!rst_n) begin
         m_phase = PH_IDLE; m_lives = LIVES; m_pix = 0; m_cars = '0;
         m_left = 0; m_hitcar = '0;
      end else if (!act) begin
         m_phase  = PH_IDLE;
         m_hitcar = '0;
      end else begin
         case (m_phase)
            PH_IDLE: begin
               m_lives = LIVES; m_pix = 0; m_cars = '0; m_phase = PH_PLAY;
            end
            PH_PLAY: begin
               if (fs) begin
                  if (m_pix >= HIT) begin
                     m_hit    = 1'b1;
                     m_hitcar = m_cars;
                     m_lives  = (m_lives > 0) ? m_lives - 1 : 0;
                     m_phase  = (m_lives == 0) ? PH_OVER : PH_FREEZE;
                     m_left   = FRZ;
                  end
                  m_pix  = ov ? 1 : 0;
                  m_cars = ov ? car : '0;
               end else if (ov) begin
                  m_pix++;
                  m_cars |= car;
               end
            end
            PH_FREEZE: begin
               if (fs) begin
                  m_left--;
                  if (m_left == 0) begin
                     m_resp  = 1'b1;
                     m_phase = PH_GRACE;
                     m_left  = GRC;
                  end
               end
            end
            PH_GRACE: begin
               if (fs) begin
                  m_left--;
                  if (m_left == 0) begin
                     m_phase = PH_PLAY; m_pix = 0; m_cars = '0;
                  end
               end
            end
            default: ;
         endcase
      end
   endtask

   // Drive one cycle, step the model on the edge, compare all outputs after it.
   task automatic cyc(input logic rst_n, input logic act, input logic fs,
                      input logic frog, input logic [NC-1:0] car);
      rst_n_in = rst_n; act_in = act; fs_in = fs; frog_in = frog; car_in = car;
      @(posedge clk);
      model_update(rst_n, act, fs, frog, car);
      #1;
      check_eq("hit",       32'(hit_out),     32'(m_hit));
      check_eq("hit_car",   32'(hit_car_out), 32'(m_hitcar));
      check_eq("freeze",    32'(freeze_out),  32'(m_phase == PH_FREEZE));
      check_eq("respawn",   32'(respawn_out), 32'(m_resp));
      check_eq("grace",     32'(grace_out),   32'(m_phase == PH_GRACE));
      check_eq("lives",     32'(lives_out),   32'(m_lives));
      check_eq("game_over", 32'(over_out),    32'(m_phase == PH_OVER));
      cycle++;
   endtask

   task automatic overlaps(input int n, input logic [NC-1:0] car);
      repeat (n) cyc(1'b1, 1'b1, 1'b0, 1'b1, car);
   endtask

   task automatic skip_frames(input int n);
      repeat (n) begin
         cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
         cyc(1'b1, 1'b1, 1'b1, 1'b0, '0);
      end
   endtask

   initial begin
      rst_n_in = 1'b0; act_in = 1'b0; fs_in = 1'b0; frog_in = 1'b0; car_in = '0;

      // Reset state.
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
      check_eq("rst_lives", 32'(lives_out), 32'd3);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);          // IDLE -> PLAY

      // Threshold: 3 overlaps are not a hit.
      overlaps(3, 4'b0001);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, '0);
      check_eq("thr_nohit", 32'(hit_out), 32'd0);

      // Hit with car 2.
      overlaps(4, 4'b0100);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, '0);
      check_eq("dir_hit",     32'(hit_out),     32'd1);
      check_eq("dir_hit_car", 32'(hit_car_out), 32'h4);
      check_eq("dir_lives",   32'(lives_out),   32'd2);
      check_eq("dir_freeze",  32'(freeze_out),  32'd1);

      // Freeze then grace, with overlaps ignored in grace.
      skip_frames(2);
      check_eq("dir_respawn", 32'(respawn_out), 32'd1);
      check_eq("dir_grace",   32'(grace_out),   32'd1);
      overlaps(5, 4'b1000);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'b1000);
      overlaps(5, 4'b1000);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, '0);
      check_eq("dir_play_again", 32'(grace_out), 32'd0);

      // Second hit, then last life -> game over.
      overlaps(4, 4'b0010);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, '0);
      skip_frames(4);
      overlaps(4, 4'b0001);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, '0);
      check_eq("over_flag",  32'(over_out),  32'd1);
      check_eq("over_lives", 32'(lives_out), 32'd0);
      skip_frames(3);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
      check_eq("over_idle", 32'(over_out), 32'd0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
      check_eq("reload_lives", 32'(lives_out), 32'd3);

      // Abort mid-freeze: no respawn.
      overlaps(4, 4'b0100);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, '0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
      check_eq("abort_freeze", 32'(freeze_out), 32'd0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);

      // Game inactive on the evaluating frame start: no hit.
      overlaps(4, 4'b0100);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
      check_eq("abort_eval_lives", 32'(lives_out), 32'd3);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);

      // Reset mid-play with overlaps pending.
      overlaps(3, 4'b0010);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
      check_eq("rst_play_lives", 32'(lives_out), 32'd3);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, '0);

      // Saturation: 300 overlaps give one hit.
      overlaps(300, 4'b0011);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, '0);
      check_eq("sat_hit_car", 32'(hit_car_out), 32'h3);
      skip_frames(5);

      // Random traffic.
      repeat (4000) begin
         cyc(1'($urandom_range(0, 499) != 0),
             1'($urandom_range(0, 199) != 0),
             1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
